// File: rtl/ps4b_tx.sv
// Parallel-in, serial-out transmitter for the 4-bit serial link.
// Captures P on an accepted load and shifts it out one bit per clk with a valid qualifier.
module ps4b_tx #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_LVL  = 1'b0
) (
    input  logic                       clk,
    input  logic                       CLR,
    input  logic                       load,
    input  logic [WIDTH-1:0]           P,
    output logic                       ready,
    output logic                       S,
    output logic                       valid,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(WIDTH)-1:0]   cnt
);

    localparam int unsigned CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [CW-1:0]    cnt_n;
    logic             last_bit;
    logic             out_bit;

    assign last_bit = (state == SHIFT) && (cnt == LAST);
    assign ready    = (state == IDLE) || (cnt == LAST);

    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (load) begin
                    sreg_n  = P;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    if (load) begin
                        sreg_n = P;
                    end else begin
                        sreg_n  = '0;
                        state_n = IDLE;
                    end
                end else begin
                    sreg_n = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
                    cnt_n  = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // S is registered from the next-state shift register so it stays a pure flop output
    assign out_bit = MSB_FIRST ? sreg_n[WIDTH-1] : sreg_n[0];

    always_ff @(posedge clk) begin
        if (CLR) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            S     <= IDLE_LVL;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            sreg  <= sreg_n;
            cnt   <= cnt_n;
            S     <= (state_n == SHIFT) ? out_bit : IDLE_LVL;
            valid <= (state_n == SHIFT);
            busy  <= (state_n == SHIFT);
            done  <= last_bit;
        end
    end

endmodule

// File: tb/tb_ps4b_tx.sv
// Directed self-checking bench for ps4b_tx; two instances cover MSB-first and LSB-first
// orders, each paired with a bench-side SIPO receiver for loopback.
module tb_ps4b_tx;

    logic       clk = 1'b0;
    logic       CLR, load;
    logic [3:0] P;

    logic       rdy1, s1, v1, b1, d1;
    logic [1:0] c1;
    logic       rdy0, s0, v0, b0, d0;
    logic [1:0] c0;
    logic [3:0] rx1, rx0;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    ps4b_tx #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LVL(1'b0)) u_msb (
        .clk(clk), .CLR(CLR), .load(load), .P(P),
        .ready(rdy1), .S(s1), .valid(v1), .busy(b1), .done(d1), .cnt(c1)
    );

    ps4b_tx #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LVL(1'b0)) u_lsb (
        .clk(clk), .CLR(CLR), .load(load), .P(P),
        .ready(rdy0), .S(s0), .valid(v0), .busy(b0), .done(d0), .cnt(c0)
    );

    // Receivers: MSB-first shifts toward its MSB, LSB-first toward its LSB
    always @(posedge clk) begin
        if (v1) rx1 <= {rx1[2:0], s1};
        if (v0) rx0 <= {s0, rx0[3:1]};
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Checks one frame bit on the MSB-first instance
    task automatic bit1(input string tag, input logic e, input logic [1:0] idx);
        chk({tag, "_S"}, 16'(s1), 16'(e));
        chk({tag, "_valid"}, 16'(v1), 16'd1);
        chk({tag, "_busy"}, 16'(b1), 16'd1);
        chk({tag, "_cnt"}, 16'(c1), 16'(idx));
    endtask

    task automatic idle1(input string tag);
        chk({tag, "_S"}, 16'(s1), 16'd0);
        chk({tag, "_valid"}, 16'(v1), 16'd0);
        chk({tag, "_busy"}, 16'(b1), 16'd0);
        chk({tag, "_ready"}, 16'(rdy1), 16'd1);
    endtask

    initial begin
        CLR = 1'b1; load = 1'b1; P = 4'hF;
        @(negedge clk);
        step(); step();
        idle1("rst");
        chk("rst_done", 16'(d1), 16'd0);
        chk("rst_cnt", 16'(c1), 16'd0);
        chk("rst_lsb_valid", 16'(v0), 16'd0);

        CLR = 1'b0; load = 1'b0;
        step();
        idle1("post_rst");

        // Single frame 1011
        P = 4'b1011; load = 1'b1;
        step(); load = 1'b0; P = 4'h0;
        chk("sf_ready0", 16'(rdy1), 16'd0);
        chk("sf_lsb_S0", 16'(s0), 16'd1);
        bit1("sf_b0", 1'b1, 2'd0); step();
        chk("sf_lsb_S1", 16'(s0), 16'd1);
        bit1("sf_b1", 1'b0, 2'd1); step();
        chk("sf_lsb_S2", 16'(s0), 16'd0);
        bit1("sf_b2", 1'b1, 2'd2); step();
        chk("sf_lsb_S3", 16'(s0), 16'd1);
        bit1("sf_b3", 1'b1, 2'd3);
        chk("sf_ready_last", 16'(rdy1), 16'd1);
        chk("sf_done_early", 16'(d1), 16'd0);
        step();
        chk("sf_done", 16'(d1), 16'd1);
        idle1("sf_idle");
        step();
        chk("sf_done_clr", 16'(d1), 16'd0);

        // Back-to-back 1011 then 0110
        P = 4'b1011; load = 1'b1;
        step(); load = 1'b0;
        bit1("bb_b0", 1'b1, 2'd0); step();
        bit1("bb_b1", 1'b0, 2'd1); step();
        bit1("bb_b2", 1'b1, 2'd2); step();
        bit1("bb_b3", 1'b1, 2'd3);
        P = 4'b0110; load = 1'b1;
        step(); load = 1'b0;
        chk("bb_done1", 16'(d1), 16'd1);
        bit1("bb_b4", 1'b0, 2'd0); step();
        chk("bb_done1_clr", 16'(d1), 16'd0);
        bit1("bb_b5", 1'b1, 2'd1); step();
        bit1("bb_b6", 1'b1, 2'd2); step();
        bit1("bb_b7", 1'b0, 2'd3); step();
        chk("bb_done2", 16'(d1), 16'd1);
        idle1("bb_idle");
        step();

        // Load while busy is ignored
        P = 4'b1001; load = 1'b1;
        step(); load = 1'b0;
        bit1("lb_b0", 1'b1, 2'd0); step();
        bit1("lb_b1", 1'b0, 2'd1);
        P = 4'b0000; load = 1'b1;
        step(); load = 1'b0;
        bit1("lb_b2", 1'b0, 2'd2); step();
        bit1("lb_b3", 1'b1, 2'd3); step();
        chk("lb_done", 16'(d1), 16'd1);
        idle1("lb_idle");
        step();
        idle1("lb_idle2");

        // Reset mid-frame
        P = 4'b1110; load = 1'b1;
        step(); load = 1'b0;
        bit1("rm_b0", 1'b1, 2'd0); step();
        bit1("rm_b1", 1'b1, 2'd1); step();
        bit1("rm_b2", 1'b1, 2'd2);
        CLR = 1'b1;
        step(); CLR = 1'b0;
        idle1("rm_clr");
        chk("rm_no_done", 16'(d1), 16'd0);
        chk("rm_cnt", 16'(c1), 16'd0);
        step();
        idle1("rm_after");
        chk("rm_no_done2", 16'(d1), 16'd0);
        P = 4'b0101; load = 1'b1;
        step(); load = 1'b0;
        bit1("rm_n0", 1'b0, 2'd0); step();
        bit1("rm_n1", 1'b1, 2'd1); step();
        bit1("rm_n2", 1'b0, 2'd2); step();
        bit1("rm_n3", 1'b1, 2'd3); step();
        chk("rm_n_done", 16'(d1), 16'd1);
        chk("rm_n_rx1", 16'(rx1), 16'h5);
        step();

        // Loopback: three back-to-back frames into both receivers
        P = 4'b1100; load = 1'b1;
        step(); load = 1'b0;
        step(); step(); step();
        chk("lp_v_mid1", 16'(v1), 16'd1);
        P = 4'b0011; load = 1'b1;
        step(); load = 1'b0;
        chk("lp_done1", 16'(d1), 16'd1);
        chk("lp_valid1", 16'(v1), 16'd1);
        chk("lp_rx1_f1", 16'(rx1), 16'hC);
        chk("lp_rx0_f1", 16'(rx0), 16'hC);
        step(); step(); step();
        P = 4'b1010; load = 1'b1;
        step(); load = 1'b0;
        chk("lp_done2", 16'(d0), 16'd1);
        chk("lp_valid2", 16'(v0), 16'd1);
        chk("lp_rx1_f2", 16'(rx1), 16'h3);
        chk("lp_rx0_f2", 16'(rx0), 16'h3);
        step(); step(); step(); step();
        chk("lp_done3", 16'(d1), 16'd1);
        chk("lp_rx1_f3", 16'(rx1), 16'hA);
        chk("lp_rx0_f3", 16'(rx0), 16'hA);
        chk("lp_idle_v1", 16'(v1), 16'd0);
        chk("lp_idle_v0", 16'(v0), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
